// File: rtl/baw_uart_streamer.sv
// -----------------------------------------------------------------------------
// baw_uart_streamer
//   Captures black/white pixel pairs from the CeNN threshold stage, buffers
//   them in a small FIFO and sends each pair over a UART TX line.
//   The line format is 8N1, LSB first, with byte 0 (PE[0]) sent before byte 1 (PE[n]).
//   Pairs that arrive while the FIFO is full are dropped, and the sticky
//   overflow flag is set.
//
// Handshake: pixel_valid is a one-cycle strobe with no back-pressure. A pair
//   is accepted on the rising edge where pixel_valid=1 and the FIFO has room.
//   The FIFO also has room when the transmitter pops the head on that same
//   edge. Otherwise the pair is lost and overflow is set.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   pixel_valid   strobe, black_white_0/_x valid this cycle
//   black_white_0 pixel byte from PE[0]
//   black_white_x pixel byte from PE[n]
//   tx            UART serial out (idle high), driven from a flop
//   busy          frame in flight or FIFO non-empty
//   fifo_count    entries stored, 0..FIFO_DEPTH
//   overflow      sticky, a pair was dropped
// -----------------------------------------------------------------------------
module baw_uart_streamer #(
  parameter int width_BaW    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_valid,
  input  logic [width_BaW-1:0] black_white_0,
  input  logic [width_BaW-1:0] black_white_x,
  output logic                 tx,
  output logic                 busy,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 overflow
);

  localparam int ENTRY_W = 2 * width_BaW;
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = (width_BaW > 1) ? $clog2(width_BaW) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(width_BaW - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // FIFO state
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;

  // TX state
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [width_BaW-1:0] shift_q, shift_d;
  logic [width_BaW-1:0] byte1_q, byte1_d;
  logic                 byte_sel_q, byte_sel_d;
  logic                 tx_q, tx_d;

  logic                 push, pop, baud_last;
  logic [ENTRY_W-1:0]   head;
  logic [BIT_W-1:0]     bit_nxt;

  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BAUD_LAST);
  assign bit_nxt   = bit_q + BIT_W'(1);

  // The head is popped only on the edge where the FSM leaves IDLE.
  // A push is still accepted at full when that pop frees a slot on the same edge.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign push = pixel_valid && ((count_q != DEPTH_C) || pop);

  // ---------------------------------------------------------------------------
  // FIFO next state. The depth is a power of two, so the pointers wrap naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (pixel_valid & ~push);
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX FSM next state. tx_d is the line level for the cycle after this edge.
  // This keeps the pin on a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte1_d    = byte1_q;
    byte_sel_d = byte_sel_q;
    tx_d       = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d    = head[width_BaW-1:0];
          byte1_d    = head[ENTRY_W-1:width_BaW];
          byte_sel_d = 1'b0;
          baud_d     = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            // Second byte of the pair follows with no idle gap.
            shift_d    = byte1_q;
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      byte_sel_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      byte_sel_q <= byte_sel_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset. Only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {black_white_x, black_white_0};
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_baw_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_baw_uart_streamer
//   Self-checking bench for baw_uart_streamer with CLKS_PER_BIT=4 and
//   FIFO_DEPTH=4. Pairs are pushed into an expected-byte queue when they are
//   driven. A UART receiver process decodes tx and pops and compares each byte.
//   It also records the cycle at which each start bit begins.
// -----------------------------------------------------------------------------
module tb_baw_uart_streamer;

  localparam int W     = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pixel_valid = 1'b0;
  logic [W-1:0]  bw0 = '0;
  logic [W-1:0]  bwx = '0;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  baw_uart_streamer #(
    .width_BaW    (W),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_valid   (pixel_valid),
    .black_white_0 (bw0),
    .black_white_x (bwx),
    .tx            (tx),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           start_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic         mon_en = 1'b1;
  logic         mon_busy = 1'b0;
  int           peak = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int start_at(input int i);
    return (i < start_q.size()) ? start_q[i] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Called #1 after a rising edge. The pair is sampled on the next edge.
  task automatic drive_pair(input logic [W-1:0] b0, input logic [W-1:0] bx, input bit accept);
    pixel_valid = 1'b1;
    bw0 = b0;
    bwx = bx;
    if (accept) begin
      exp_q.push_back(b0);
      exp_q.push_back(bx);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || mon_busy) && n < 4000) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain_timeout"}, 32'(busy || mon_busy), 32'd0);
    check_eq({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // UART receiver: samples the middle of each bit on falling edges.
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rx_byte;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        check_eq("rx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < W; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check_eq("rx_stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("rx_unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
        repeat (CPB / 2 - 1) @(negedge clk);
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int  t0;
    bit  line_ok;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single pair: latency, fifo_count 1->0, busy length of 80 cycles
    start_q.delete();
    drive_pair(8'h00, 8'hFF, 1'b1);
    t0 = cyc;
    @(negedge clk);
    check_eq("t2_count_after_push", 32'(fifo_count), 32'd1);
    check_eq("t2_tx_before_pop", 32'(tx), 32'd1);
    check_eq("t2_busy_after_push", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t2_tx_fall", 32'(tx), 32'd0);
    check_eq("t2_count_after_pop", 32'(fifo_count), 32'd0);
    repeat (79) @(negedge clk);
    check_eq("t2_busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t2_busy_drop", 32'(busy), 32'd0);
    wait_idle("t2");
    check_eq("t2_start0", 32'(start_at(0)), 32'(t0 + 1));
    check_eq("t2_start1", 32'(start_at(1)), 32'(t0 + 1 + 10 * CPB));

    // Back-to-back pairs: one idle cycle between pairs, peak count 2
    @(posedge clk); #1;
    start_q.delete();
    peak = 0;
    drive_pair(8'h00, 8'hFF, 1'b1);
    t0 = cyc;
    drive_pair(8'hFF, 8'h00, 1'b1);
    drive_pair(8'hA5, 8'h5A, 1'b1);
    wait_idle("t3");
    check_eq("t3_peak", 32'(peak), 32'd2);
    for (int p = 0; p < 3; p++) begin
      check_eq("t3_pair_start_b0", 32'(start_at(2 * p)), 32'(t0 + 1 + p * (20 * CPB + 1)));
      check_eq("t3_pair_start_b1", 32'(start_at(2 * p + 1)),
               32'(t0 + 1 + p * (20 * CPB + 1) + 10 * CPB));
    end

    // Overflow: 6 pushes while the first frame runs, so the 6th is dropped
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      drive_pair(8'(8'h10 + i), 8'(8'hE0 + i), i < 5);
    end
    check_eq("t4_count_full", 32'(fifo_count), 32'd4);
    check_eq("t4_overflow_set", 32'(overflow), 32'd1);
    wait_idle("t4");
    check_eq("t4_overflow_sticky", 32'(overflow), 32'd1);
    check_eq("t4_count_drained", 32'(fifo_count), 32'd0);

    // Mid-sim reset: outputs clear without a clock edge
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("t1_tx", 32'(tx), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_count", 32'(fifo_count), 32'd0);
    check_eq("t1_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Push at full coinciding with a pop: accepted, count stays 4
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive_pair(8'(8'h30 + i), 8'(8'hC0 + i), 1'b1);
    end
    repeat (20 * CPB - 3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("t5_count_before", 32'(fifo_count), 32'd4);
    check_eq("t5_idle_tx", 32'(tx), 32'd1);
    drive_pair(8'h77, 8'h88, 1'b1);
    check_eq("t5_count_after", 32'(fifo_count), 32'd4);
    check_eq("t5_overflow", 32'(overflow), 32'd0);
    check_eq("t5_tx_start", 32'(tx), 32'd0);
    wait_idle("t5");
    check_eq("t5_overflow_end", 32'(overflow), 32'd0);

    // Random pairs with random gaps wide enough to never overflow
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      drive_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(20, 60)) @(posedge clk);
      #1;
    end
    wait_idle("rand");
    check_eq("rand_overflow", 32'(overflow), 32'd0);

    // Reset during DATA bit 3 of byte 0 (0xA5 bit 3 = 0)
    mon_en = 1'b0;
    @(posedge clk); #1;
    drive_pair(8'hA5, 8'h3C, 1'b0);
    repeat (18) @(negedge clk);
    check_eq("t6_tx_bit3", 32'(tx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_tx_async", 32'(tx), 32'd1);
    check_eq("t6_busy_async", 32'(busy), 32'd0);
    rst = 1'b0;
    line_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
    end
    check_eq("t6_line_quiet", 32'(line_ok), 32'd1);
    check_eq("t6_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baw_uart_streamer.md
Name: baw_uart_streamer

Overview:
- Downstream of the CeNN threshold stage (fixed2BaW). Captures each pair of black/white pixel bytes (PE 0 and PE n outputs) on a valid strobe.
- Buffers captured pairs in a small FIFO.
- Serializes them over a UART TX line (8N1, LSB first) to the host, which reconstructs the thresholded image.
- Decouples CeNN pixel rate from the slow serial link; reports loss on overflow.

Parameters:
- width_BaW, 8, width of each pixel byte
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200)
- FIFO_DEPTH, 16, number of pixel-pair entries; power of two
- ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pixel_valid  input  1  one-cycle strobe; black_white_0/_x hold a valid pair this cycle
- black_white_0  input  width_BaW  pixel byte from PE[0] (0 black, 255 white)
- black_white_x  input  width_BaW  pixel byte from PE[n]
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a frame is being sent or FIFO non-empty
- fifo_count  output  ADDR_W+1  entries currently stored, 0..FIFO_DEPTH
- overflow  output  1  sticky; a pair was dropped because FIFO was full

Behaviour:
Reset (async, rst=1):
- tx=1, busy=0, fifo_count=0, overflow=0.
- FIFO pointers 0, FSM=IDLE, bit and baud counters 0.
- Asserting rst mid-frame aborts the frame immediately; tx returns high asynchronously and no partial byte resumes.

FIFO:
- Entry = {black_white_x, black_white_0}, 2*width_BaW bits.
- Push on the edge where pixel_valid=1 and (count<FIFO_DEPTH or a pop occurs the same edge).
- pixel_valid=1 with count=FIFO_DEPTH and no pop: pair dropped, overflow<=1, count unchanged.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count is registered and reflects the edge's push/pop.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE: if count!=0, pop the head entry on this edge, load shift register with byte 0 (black_white_0), set byte_sel=0, go START. tx is driven 0 from this edge.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go DATA with bit_idx=0.
- DATA: tx=shift[bit_idx] for CLKS_PER_BIT cycles each, LSB first. After bit 7, go STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_sel=0: load byte 1 (black_white_x), byte_sel=1, go START with no idle gap.
  - else go IDLE.
- A pair therefore occupies exactly 20*CLKS_PER_BIT cycles on the line.
- Back-to-back pairs have one idle cycle (tx=1) between pairs, spent in IDLE performing the pop.

Timing and latency:
- Latency: pixel_valid at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1 → tx falls at edge N+1.
- busy = (state!=IDLE) || (count!=0), registered-equivalent (no glitches on tx).
- Baud counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary; no accumulated drift.
- tx is driven from a flop.

Input values:
- Values other than 0/255 are transmitted unmodified; the block does not validate pixel content.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 for sim):
1. Reset: apply rst mid-sim, sample immediately → tx=1, busy=0, fifo_count=0, overflow=0 without waiting for a clock edge.
2. Single pair: pixel_valid with bw_0=0x00, bw_x=0xFF → tx falls 1 cycle later, then:
   - start 4 cycles, eight 0s ×4, stop 4;
   - start 4, eight 1s ×4, stop 4;
   - busy drops after 80 cycles from the first tx fall; fifo_count 1→0 at the pop edge.
3. Back-to-back: 3 pairs (0x00,0xFF), (0xFF,0x00), (0xA5,0x5A) on consecutive cycles → decoded byte stream 00 FF FF 00 A5 5A, exactly one idle-high cycle between pairs, fifo_count peaks at 2.
4. Overflow: 6 pushes on consecutive cycles while the first frame is running → 1 popped + 4 stored, 6th dropped, overflow=1 and stays 1 after the FIFO drains; transmitted pairs are the first 5 only.
5. Push with simultaneous pop at full: FIFO full, FSM reaches IDLE pop edge with pixel_valid=1 → pair accepted, fifo_count stays 4, overflow stays 0.
6. Reset mid-frame: assert rst during DATA bit 3 of byte 0 → tx=1 immediately; after release with no new input, tx stays high and busy=0.
